systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencer for the weight-stationary systolic multiply array. It loads one weight row per beat into the cells' weight registers and clears the array pipeline. It then streams activation vectors into the array's left edge with per-row skew and deskews the bottom-row column sums into one aligned result vector per input vector. It sits between the host-side weight/activation streams and a `systolarray`-style N×N grid of multiply-accumulate cells.

## Interface
- `DATA_SIZE`, 8, width of one weight or activation element.
- `ARRAY_SIZE`, 2, array dimension N (rows = columns = N), N ≥ 2.
- `CNT_W`, 8, width of the vector-count field.

- `clk` in 1: single clock; all logic posedge.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `start` in 1: begin a job; sampled only in IDLE.
- `num_vecs` in CNT_W: number of activation vectors in the job; latched on `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at job end.
- `w_valid` / `w_ready` in/out 1: weight row handshake.
- `w_data` in N*DATA_SIZE: one weight row; element c in bits [c*DATA_SIZE +: DATA_SIZE].
- `a_valid` / `a_ready` in/out 1: activation vector handshake.
- `a_data` in N*DATA_SIZE: one activation vector; element r drives array row r.
- `res_valid` out 1: aligned result vector present. There is no ready; the consumer must always accept.
- `res_data` out N*2*DATA_SIZE: column c sum in bits [c*2*DATA_SIZE +: 2*DATA_SIZE].
- `arr_w` out N*DATA_SIZE: weight row to the array.
- `arr_wload` out N: one-hot row weight-load strobe.
- `arr_a` out N*DATA_SIZE: skewed left-edge activations.
- `arr_clr` out 1: array pipeline reset.
- `arr_res` in N*2*DATA_SIZE: bottom-row partial sums from the array.

## Operation
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → CLEAR after N accepted weight beats.
  - CLEAR (exactly 1 cycle) → STREAM, or → DONE if `num_vecs` == 0.
  - STREAM → DRAIN after `num_vecs` vectors are accepted.
  - DRAIN → DONE when the valid pipe is empty.
  - DONE (1 cycle) → IDLE.
- LOAD behaviour:
  - `w_ready` is high only in LOAD.
  - Beat r (r = 0..N-1) is accepted on `w_valid & w_ready`.
  - In that same cycle `arr_wload` = 1<<r and `arr_w` = `w_data`.
  - Otherwise `arr_wload` = 0 and `arr_w` = 0.
- `arr_clr` is high only in CLEAR and while `reset` is high.
- STREAM behaviour:
  - `a_ready` = 1 in STREAM until the count reaches `num_vecs`; 0 in every other state.
  - An accepted element r is delayed r cycles through a per-row skew register before appearing on `arr_a` row r.
  - On a cycle with no acceptance (bubble), a zero element enters the skew chain.
- Valid tracking: a valid-bit shift register of depth 2N is fed 1 on acceptance and 0 otherwise. Its tail drives `res_valid`.
- Deskew: `arr_res` column c is delayed (N-1-c) cycles, so all columns of one vector emerge together on `res_data`.
- `res_data` = 0 whenever `res_valid` = 0.
- The controller performs no arithmetic. Sum width and overflow behaviour (wrap modulo 2^(2*DATA_SIZE)) belong to the array.
- `start` outside IDLE is ignored. `num_vecs` changes after latch are ignored.
- `reset` mid-job:
  - Next state is IDLE, and all skew, deskew and valid registers clear.
  - In-flight results are discarded; no `done` pulse.

## Timing
- Reset values:
  - `busy`, `done`, `w_ready`, `a_ready`, `res_valid`, `arr_wload` = 0.
  - `res_data`, `arr_w`, `arr_a` = 0.
  - `arr_clr` = 1 while `reset` is high.
- `start` at edge k: LOAD from cycle k+1. The earliest LOAD exit is N cycles later with `w_valid` held high.
- The array contract assumed by this block: one register per cell; activations shift one column right per cycle; sums shift one row down per cycle.
- Latency: a vector accepted at edge k has `res_valid` high with its result for exactly one cycle after edge k+2N.
- Back-to-back vectors yield back-to-back results. Input bubbles reproduce as identical `res_valid` gaps.
- DRAIN exits when the valid pipe is all-zero. `done` pulses exactly 2N+1 cycles after the last acceptance (CLEAR-only job: 1 cycle after CLEAR).
- `busy` falls in the cycle after `done`.

## Test plan
- Basic job:
  - Stimulus: N=2, W rows [1,2] then [3,4], one vector a=[5,6].
  - Required: `arr_wload` = 01 then 10; `res_valid` 4 cycles after acceptance; `res_data` = {34, 23}; `done` 5 cycles after acceptance.
- Burst:
  - Stimulus: 4 vectors [1,0],[0,1],[2,2],[255,255] back-to-back with `a_valid` constant.
  - Required: 4 consecutive results [1,2],[3,4],[8,12],[1020,1530].
- Bubbles:
  - Stimulus: the same 4 vectors with `a_valid` low for 2 cycles between 2nd and 3rd.
  - Required: the identical 2-cycle gap in `res_valid`; values unchanged.
- Zero count:
  - Stimulus: `num_vecs` = 0.
  - Required: LOAD→CLEAR→DONE; `a_ready` never high; `res_valid` never high; `done` once.
- Reset mid-job:
  - Stimulus: assert `reset` 1 cycle after 2nd of 4 acceptances.
  - Required: next cycle `busy` = 0, `res_valid` = 0, `arr_clr` = 1 during reset; no `done`; a fresh job afterwards gives correct results.
- Start ignored:
  - Stimulus: `start` pulses during LOAD and STREAM; `w_valid` low for 3 cycles in LOAD.
  - Required: no restart; LOAD stalls until rows complete.

Source files
------------

// File: rtl/systolic_ctrl.sv
`timescale 1ns/1ps
// systolic_ctrl: sequencer for an N x N weight-stationary systolic array.
// Loads one weight row per beat, clears the array pipeline, streams skewed
// activations into the left edge and deskews bottom-row column sums into
// one aligned result vector per accepted activation vector.
module systolic_ctrl #(
  parameter int DATA_SIZE  = 8,
  parameter int ARRAY_SIZE = 2,
  parameter int CNT_W      = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [CNT_W-1:0]                    num_vecs,
  output logic                                busy,
  output logic                                done,
  input  logic                                w_valid,
  output logic                                w_ready,
  input  logic [ARRAY_SIZE*DATA_SIZE-1:0]     w_data,
  input  logic                                a_valid,
  output logic                                a_ready,
  input  logic [ARRAY_SIZE*DATA_SIZE-1:0]     a_data,
  output logic                                res_valid,
  output logic [ARRAY_SIZE*2*DATA_SIZE-1:0]   res_data,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0]     arr_w,
  output logic [ARRAY_SIZE-1:0]               arr_wload,
  output logic [ARRAY_SIZE*DATA_SIZE-1:0]     arr_a,
  output logic                                arr_clr,
  input  logic [ARRAY_SIZE*2*DATA_SIZE-1:0]   arr_res
);

  localparam int N     = ARRAY_SIZE;
  localparam int D     = DATA_SIZE;
  localparam int RES_W = 2 * DATA_SIZE;
  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
  localparam int VLD_D = 2 * N;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);
  localparam logic [N-1:0]     ROW0_HOT = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CLEAR  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ROW_W-1:0]   row_q;
  logic               busy_q;
  logic               done_q;
  logic               w_ready_q;
  logic               a_ready_q;
  logic               clr_q;
  logic [VLD_D-1:0]   vld_q;
  logic               res_valid_q;
  logic [N*RES_W-1:0] res_data_q;

  logic               w_fire;
  logic               a_fire;
  logic [N-1:0]       wload_d;
  logic [N*D-1:0]     w_d;
  logic [N*RES_W-1:0] dsk_d;

  assign w_fire = w_valid & w_ready_q;
  assign a_fire = a_valid & a_ready_q;

  // Weight-load strobe and row data are presented in the same cycle as the accepted beat.
  always_comb begin
    wload_d = '0;
    w_d     = '0;
    if (w_fire && !reset) begin
      wload_d = ROW0_HOT << row_q;
      w_d     = w_data;
    end else begin
      wload_d = '0;
      w_d     = '0;
    end
  end

  // Job sequencing FSM; status and handshake outputs are registered with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_LOAD;
            num_q     <= num_vecs;
            cnt_q     <= '0;
            row_q     <= '0;
            busy_q    <= 1'b1;
            w_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_fire) begin
            if (row_q == LAST_ROW) begin
              state_q   <= S_CLEAR;
              w_ready_q <= 1'b0;
              clr_q     <= 1'b1;
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end
        end
        S_CLEAR: begin
          clr_q <= 1'b0;
          if (num_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_STREAM;
            a_ready_q <= 1'b1;
          end
        end
        S_STREAM: begin
          if (a_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if ((cnt_q + CNT_W'(1)) == num_q) begin
              state_q   <= S_DRAIN;
              a_ready_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Leave only once every in-flight vector has reached the output.
          if (vld_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          w_ready_q <= 1'b0;
          a_ready_q <= 1'b0;
          clr_q     <= 1'b0;
        end
      endcase
    end
  end

  // Valid pipe: one bit per accepted vector, depth matching skew + array + deskew.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[VLD_D-2:0], a_fire};
    end
  end

  // Activation skew: row r is delayed r extra cycles; bubbles push zeros.
  for (genvar r = 0; r < N; r++) begin : g_skew
    logic [D-1:0] chain_q [r+1];

    // Per-row skew shift register feeding the array's left edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s <= r; s++) chain_q[s] <= '0;
      end else begin
        chain_q[0] <= a_fire ? a_data[r*D +: D] : {D{1'b0}};
        for (int s = 1; s <= r; s++) chain_q[s] <= chain_q[s-1];
      end
    end

    assign arr_a[r*D +: D] = chain_q[r];
  end

  // Deskew: column c arrives c cycles after column 0, so it is delayed N-1-c cycles.
  for (genvar c = 0; c < N; c++) begin : g_dsk
    if (c == N - 1) begin : g_direct
      assign dsk_d[c*RES_W +: RES_W] = arr_res[c*RES_W +: RES_W];
    end else begin : g_chain
      logic [RES_W-1:0] chain_q [N-1-c];

      // Per-column deskew shift register.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s < N - 1 - c; s++) chain_q[s] <= '0;
        end else begin
          chain_q[0] <= arr_res[c*RES_W +: RES_W];
          for (int s = 1; s < N - 1 - c; s++) chain_q[s] <= chain_q[s-1];
        end
      end

      assign dsk_d[c*RES_W +: RES_W] = chain_q[N-2-c];
    end
  end

  // Result output register; data is forced to zero when no vector is present.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= vld_q[VLD_D-1];
      res_data_q  <= vld_q[VLD_D-1] ? dsk_d : {(N*RES_W){1'b0}};
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_ready   = w_ready_q;
  assign a_ready   = a_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign arr_w     = w_d;
  assign arr_wload = wload_d;
  assign arr_clr   = clr_q | reset;

endmodule

// File: tb/tb_systolic_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for systolic_ctrl with a behavioural 2x2 weight-stationary array.
module tb_systolic_ctrl;
  localparam int D  = 8;
  localparam int N  = 2;
  localparam int CW = 8;
  localparam int RW = 2 * D;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [CW-1:0]   num_vecs;
  logic            busy, done, w_valid, w_ready, a_valid, a_ready, res_valid, arr_clr;
  logic [N*D-1:0]  w_data, a_data, arr_w, arr_a;
  logic [N*RW-1:0] res_data, arr_res;
  logic [N-1:0]    arr_wload;

  always #5 clk = ~clk;

  systolic_ctrl #(.DATA_SIZE(D), .ARRAY_SIZE(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_vecs(num_vecs),
    .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .res_valid(res_valid), .res_data(res_data),
    .arr_w(arr_w), .arr_wload(arr_wload), .arr_a(arr_a), .arr_clr(arr_clr), .arr_res(arr_res)
  );

  // Behavioural array: one register per cell, activations move right, sums move down.
  logic [D-1:0]  m_w [N][N];
  logic [D-1:0]  m_a [N][N];
  logic [RW-1:0] m_s [N][N];

  always @(posedge clk) begin : arr_model
    logic [D-1:0]  ain;
    logic [RW-1:0] sin;
    for (int r = 0; r < N; r++)
      if (arr_wload[r]) for (int c = 0; c < N; c++) m_w[r][c] <= arr_w[c*D +: D];
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        ain = (c == 0) ? arr_a[r*D +: D] : m_a[r][c-1];
        sin = (r == 0) ? {RW{1'b0}} : m_s[r-1][c];
        if (arr_clr) begin
          m_a[r][c] <= '0;
          m_s[r][c] <= '0;
        end else begin
          m_a[r][c] <= ain;
          m_s[r][c] <= sin + RW'(ain) * RW'(m_w[r][c]);
        end
      end
    end
  end

  always_comb begin
    arr_res = '0;
    for (int c = 0; c < N; c++) arr_res[c*RW +: RW] = m_s[N-1][c];
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [N*RW-1:0] data; int cyc; } exp_t;
  exp_t sb[$];
  int done_cnt = 0, done_cyc = 0, aready_cnt = 0;
  logic done_busy = 1'b0;

  // Monitor: pops one expectation per presented result and checks data and arrival cycle.
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: got res_data %0h, no result expected (cycle %0d)", res_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_cycle", cyc, e.cyc);
      end
    end else if (reset === 1'b0) begin
      chk("res_idle_zero", res_data, 0);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    if (a_ready === 1'b1) aready_cnt++;
  end

  logic [N*D-1:0]  w_rows [N];
  logic [N*D-1:0]  vec    [5];
  logic [N*RW-1:0] vexp   [5];
  int last_w_cyc = 0, last_acc = 0;

  task automatic do_start(input int nv);
    @(posedge clk); #1;
    start = 1'b1; num_vecs = CW'(nv);
    @(posedge clk); #1;
    start = 1'b0; num_vecs = 8'd77;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("w_ready_in_load", w_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic load_weights(input bit stall);
    int t;
    for (int r = 0; r < N; r++) begin
      if (stall && r == 1) begin
        w_valid = 1'b0; w_data = '0;
        for (int s = 0; s < 3; s++) begin
          start = (s == 1);
          @(negedge clk);
          chk("stall_w_ready", w_ready, 1);
          chk("stall_wload", arr_wload, 0);
          @(posedge clk); #1;
        end
        start = 1'b0;
      end
      w_valid = 1'b1; w_data = w_rows[r];
      t = 0;
      @(negedge clk);
      while (w_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      if (w_ready !== 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL w_ready_timeout: w_ready %b, required 1 for row %0d", w_ready, r);
      end else begin
        chk("arr_wload", arr_wload, N'(1) << r);
        chk("arr_w", arr_w, w_rows[r]);
        last_w_cyc = cyc + 1;
      end
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_data = '0;
    @(negedge clk);
    chk("clear_arr_clr", arr_clr, 1);
    chk("clear_w_ready", w_ready, 0);
    chk("clear_a_ready", a_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_vec(input int idx, input bit push);
    int t;
    a_valid = 1'b1; a_data = vec[idx];
    t = 0;
    @(negedge clk);
    chk("a_ready_stream", a_ready, 1);
    while (a_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (a_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL a_ready_timeout: a_ready %b, required 1 for vector %0d", a_ready, idx);
    end else begin
      last_acc = cyc + 1;
      if (push) sb.push_back('{vexp[idx], last_acc + 2 * N});
    end
    @(posedge clk); #1;
    a_valid = 1'b0; a_data = '0;
  endtask

  task automatic run_job(input int first, input int nv, input bit stall,
                         input int gap_after, input bit start_in_stream);
    int d0, a0, exp_done, t;
    d0 = done_cnt; a0 = aready_cnt;
    do_start(nv);
    load_weights(stall);
    for (int i = 0; i < nv; i++) begin
      if (start_in_stream && i == 1) start = 1'b1;
      send_vec(first + i, 1'b1);
      start = 1'b0;
      if (i == gap_after) begin repeat (2) @(posedge clk); #1; end
    end
    exp_done = (nv > 0) ? (last_acc + 2 * N + 1) : (last_w_cyc + 1);
    t = 0;
    while (done_cnt == d0 && t < 60) begin @(posedge clk); t++; end
    chk("done_count", done_cnt, d0 + 1);
    chk("done_cycle", done_cyc, exp_done);
    chk("busy_at_done", done_busy, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("results_drained", sb.size(), 0);
    if (nv == 0) chk("zero_no_a_ready", aready_cnt, a0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    w_rows[0] = {8'd2, 8'd1};           // row 0 = [1,2]
    w_rows[1] = {8'd4, 8'd3};           // row 1 = [3,4]
    vec[0] = {8'd6, 8'd5};     vexp[0] = {16'd34, 16'd23};
    vec[1] = {8'd0, 8'd1};     vexp[1] = {16'd2, 16'd1};
    vec[2] = {8'd1, 8'd0};     vexp[2] = {16'd4, 16'd3};
    vec[3] = {8'd2, 8'd2};     vexp[3] = {16'd12, 16'd8};
    vec[4] = {8'd255, 8'd255}; vexp[4] = {16'd1530, 16'd1020};

    reset = 1'b1; start = 1'b0; num_vecs = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_w_ready", w_ready, 0);   chk("rst_a_ready", a_ready, 0);
    chk("rst_res_valid", res_valid, 0); chk("rst_arr_wload", arr_wload, 0);
    chk("rst_res_data", res_data, 0); chk("rst_arr_w", arr_w, 0);
    chk("rst_arr_a", arr_a, 0);       chk("rst_arr_clr", arr_clr, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    run_job(0, 1, 1'b0, -1, 1'b0);    // basic
    run_job(1, 4, 1'b0, -1, 1'b0);    // burst
    run_job(1, 4, 1'b0, 1, 1'b0);     // bubbles after 2nd vector
    run_job(0, 0, 1'b0, -1, 1'b0);    // zero count

    // reset in the middle of a 4-vector job
    d0 = done_cnt;
    do_start(4);
    load_weights(1'b0);
    send_vec(1, 1'b0);
    send_vec(2, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_arr_clr", arr_clr, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_a_ready", a_ready, 0);
    repeat (12) @(posedge clk);
    chk("midrst_no_done", done_cnt, d0);
    #1;
    run_job(1, 4, 1'b0, -1, 1'b0);    // fresh job after reset

    run_job(1, 4, 1'b1, -1, 1'b1);    // start ignored in LOAD and STREAM, LOAD stall

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
